// File: rtl/uart_loader_if.sv
// rtl/uart_loader_if.sv - signal bundle between the UART loader and its surroundings
//
// Purpose: groups the loader's control, UART rx/tx and memory write signals.
// Modports:
//   master - the loader itself (consumes rx/enable/tx_ready, drives tx/mem/status)
//   slave  - the environment side (UART, memory arbiter, CPU stall logic)
// Signals:
//   en_i          loader enable
//   rx_valid_i    one-cycle pulse, rx_data_i valid
//   rx_data_i     received byte
//   tx_ready_i    UART transmitter can accept a byte
//   tx_valid_o    response byte pending
//   tx_data_o     response byte
//   mem_we_o      one-cycle memory write strobe
//   mem_addr_o    word-aligned byte address
//   mem_wdata_o   word written
//   hold_o        CPU hold request
//   done_o        frame accepted pulse
//   err_o         NAK or timeout pulse
interface uart_loader_if;
  logic        en_i;
  logic        rx_valid_i;
  logic [7:0]  rx_data_i;
  logic        tx_ready_i;
  logic        tx_valid_o;
  logic [7:0]  tx_data_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        hold_o;
  logic        done_o;
  logic        err_o;

  modport master (
    input  en_i, rx_valid_i, rx_data_i, tx_ready_i,
    output tx_valid_o, tx_data_o, mem_we_o, mem_addr_o, mem_wdata_o,
           hold_o, done_o, err_o
  );

  modport slave (
    output en_i, rx_valid_i, rx_data_i, tx_ready_i,
    input  tx_valid_o, tx_data_o, mem_we_o, mem_addr_o, mem_wdata_o,
           hold_o, done_o, err_o
  );
endinterface

// File: rtl/uart_loader.sv
// rtl/uart_loader.sv - UART boot loader writing framed images into memory
//
// Purpose: parses SYNC, ADDR[4], COUNT[2], DATA[4*COUNT], CHK[1] frames from
// the UART rx byte stream, writes each completed little-endian word to memory,
// and answers with ACK/NAK on the UART tx path. Holds the CPU while a frame is
// in progress.
// Ports:
//   clk   system clock
//   rst_n synchronous active-low reset
//   bus   uart_loader_if.master (enable, rx, tx, memory write, status)
module uart_loader #(
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter logic [7:0]  ACK_BYTE  = 8'h06,
  parameter logic [7:0]  NAK_BYTE  = 8'h15,
  parameter logic [31:0] TIMEOUT   = 32'd5_000_000
) (
  input  logic           clk,
  input  logic           rst_n,
  uart_loader_if.master  bus
);

  localparam logic [31:0] TMO_LAST = TIMEOUT - 32'd1;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_CNT, S_DATA, S_CHK, S_RESP
  } state_t;

  state_t      state_q, state_d;
  logic [17:0] byte_idx_q, byte_idx_d;   // field byte index; in DATA, total data bytes
  logic [23:0] word_q, word_d;           // first three bytes of the field/word in progress
  logic [29:0] addr_q, addr_d;           // ADDR[31:2]
  logic [15:0] count_q, count_d;
  logic [7:0]  chk_q, chk_d;
  logic [31:0] tmo_q, tmo_d;
  logic        tx_valid_q, tx_valid_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        hold_q, hold_d;

  logic        rx;
  logic [7:0]  rx_byte;
  logic        in_frame;
  logic        handshake;
  logic        timeout_hit;
  logic [15:0] count_m1;
  logic        last_data;
  logic [15:0] count_new;

  assign rx          = bus.rx_valid_i;
  assign rx_byte     = bus.rx_data_i;
  assign in_frame    = (state_q == S_ADDR) || (state_q == S_CNT) ||
                       (state_q == S_DATA) || (state_q == S_CHK);
  assign handshake   = bus.en_i && (state_q == S_RESP) && tx_valid_q && bus.tx_ready_i;
  // A byte arriving on the expiry cycle still counts as activity.
  assign timeout_hit = bus.en_i && in_frame && !rx && (tmo_q == TMO_LAST);
  assign count_m1    = count_q - 16'd1;
  assign last_data   = (byte_idx_q == {count_m1, 2'b11});
  // Low COUNT byte was shifted into word_q[23:16] one byte earlier.
  assign count_new   = {rx_byte, word_q[23:16]};

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      byte_idx_q  <= '0;
      word_q      <= '0;
      addr_q      <= '0;
      count_q     <= '0;
      chk_q       <= '0;
      tmo_q       <= '0;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      hold_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_idx_q  <= byte_idx_d;
      word_q      <= word_d;
      addr_q      <= addr_d;
      count_q     <= count_d;
      chk_q       <= chk_d;
      tmo_q       <= tmo_d;
      tx_valid_q  <= tx_valid_d;
      tx_data_q   <= tx_data_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      hold_q      <= hold_d;
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d     = state_q;
    byte_idx_d  = byte_idx_q;
    word_d      = word_q;
    addr_d      = addr_q;
    count_d     = count_q;
    chk_d       = chk_q;
    tmo_d       = tmo_q;
    tx_valid_d  = tx_valid_q;
    tx_data_d   = tx_data_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    hold_d      = hold_q;

    if (in_frame) begin
      tmo_d = rx ? 32'd0 : tmo_q + 32'd1;
    end

    if (!bus.en_i) begin
      state_d     = S_IDLE;
      byte_idx_d  = '0;
      word_d      = '0;
      addr_d      = '0;
      count_d     = '0;
      chk_d       = '0;
      tmo_d       = '0;
      tx_valid_d  = 1'b0;
      tx_data_d   = '0;
      mem_addr_d  = '0;
      mem_wdata_d = '0;
      hold_d      = 1'b0;
    end else if (timeout_hit) begin
      state_d = S_IDLE;
      tmo_d   = '0;
      hold_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (rx && rx_byte == SYNC_BYTE) begin
            state_d    = S_ADDR;
            byte_idx_d = '0;
            chk_d      = '0;
            tmo_d      = '0;
            hold_d     = 1'b1;
          end
        end
        S_ADDR: begin
          if (rx) begin
            chk_d      = chk_q ^ rx_byte;
            word_d     = {rx_byte, word_q[23:8]};
            byte_idx_d = byte_idx_q + 18'd1;
            if (byte_idx_q[1:0] == 2'd3) begin
              addr_d     = {rx_byte, word_q[23:2]};
              byte_idx_d = '0;
              state_d    = S_CNT;
            end
          end
        end
        S_CNT: begin
          if (rx) begin
            chk_d      = chk_q ^ rx_byte;
            word_d     = {rx_byte, word_q[23:8]};
            byte_idx_d = byte_idx_q + 18'd1;
            if (byte_idx_q[0]) begin
              count_d    = count_new;
              byte_idx_d = '0;
              if (count_new == 16'd0) begin
                state_d    = S_RESP;
                tx_valid_d = 1'b1;
                tx_data_d  = NAK_BYTE;
              end else begin
                state_d = S_DATA;
              end
            end
          end
        end
        S_DATA: begin
          if (rx) begin
            chk_d      = chk_q ^ rx_byte;
            word_d     = {rx_byte, word_q[23:8]};
            byte_idx_d = byte_idx_q + 18'd1;
            if (byte_idx_q[1:0] == 2'd3) begin
              mem_we_d    = 1'b1;
              mem_addr_d  = {addr_q, 2'b00} + {12'd0, byte_idx_q[17:2], 2'b00};
              mem_wdata_d = {rx_byte, word_q};
              if (last_data) begin
                state_d = S_CHK;
              end
            end
          end
        end
        S_CHK: begin
          if (rx) begin
            state_d    = S_RESP;
            tx_valid_d = 1'b1;
            tx_data_d  = (rx_byte == chk_q) ? ACK_BYTE : NAK_BYTE;
          end
        end
        S_RESP: begin
          if (handshake) begin
            state_d    = S_IDLE;
            tx_valid_d = 1'b0;
            tx_data_d  = '0;
            hold_d     = 1'b0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Outputs; en_i low drops everything in the same cycle.
  always_comb begin
    bus.tx_valid_o  = bus.en_i & tx_valid_q;
    bus.tx_data_o   = bus.en_i ? tx_data_q : 8'd0;
    bus.mem_we_o    = bus.en_i & mem_we_q;
    bus.mem_addr_o  = bus.en_i ? mem_addr_q : 32'd0;
    bus.mem_wdata_o = bus.en_i ? mem_wdata_q : 32'd0;
    bus.hold_o      = bus.en_i & hold_q;
    bus.done_o      = handshake && (tx_data_q == ACK_BYTE);
    bus.err_o       = (handshake && (tx_data_q != ACK_BYTE)) || timeout_hit;
  end

endmodule

// File: tb/tb_uart_loader.sv
// tb/tb_uart_loader.sv - directed self-checking bench for uart_loader
module tb_uart_loader;
  localparam logic [31:0] TMO = 32'd40;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_loader_if bus ();

  uart_loader #(.TIMEOUT(TMO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  int n_wr   = 0;
  int n_done = 0;
  int n_err  = 0;
  logic [31:0] wr_addr [$];
  logic [31:0] wr_data [$];

  always @(posedge clk) begin
    if (bus.mem_we_o) begin
      wr_addr.push_back(bus.mem_addr_o);
      wr_data.push_back(bus.mem_wdata_o);
      n_wr++;
    end
    if (bus.done_o) n_done++;
    if (bus.err_o) n_err++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_valid_i = 1'b1;
    bus.rx_data_i  = b;
    @(negedge clk);
  endtask

  task automatic rx_off();
    bus.rx_valid_i = 1'b0;
    bus.rx_data_i  = 8'h00;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic send_hdr(input logic [31:0] addr, input logic [15:0] cnt);
    send_byte(8'hA5);
    send_word(addr);
    send_byte(cnt[7:0]);
    send_byte(cnt[15:8]);
  endtask

  task automatic do_handshake(input string tag, input logic exp_done, input logic exp_err);
    bus.tx_ready_i = 1'b1;
    #1;
    check({tag, "_done"}, {31'd0, bus.done_o}, {31'd0, exp_done});
    check({tag, "_err"}, {31'd0, bus.err_o}, {31'd0, exp_err});
    @(negedge clk);
    bus.tx_ready_i = 1'b0;
    check({tag, "_txv_after"}, {31'd0, bus.tx_valid_o}, 32'd0);
    check({tag, "_hold_after"}, {31'd0, bus.hold_o}, 32'd0);
  endtask

  int wr0, done0, err0;
  bit stable;

  initial begin
    bus.en_i       = 1'b1;
    bus.rx_valid_i = 1'b0;
    bus.rx_data_i  = 8'h00;
    bus.tx_ready_i = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_txv",   {31'd0, bus.tx_valid_o}, 32'd0);
    check("rst_txd",   {24'd0, bus.tx_data_o}, 32'd0);
    check("rst_we",    {31'd0, bus.mem_we_o}, 32'd0);
    check("rst_addr",  bus.mem_addr_o, 32'd0);
    check("rst_wdata", bus.mem_wdata_o, 32'd0);
    check("rst_hold",  {31'd0, bus.hold_o}, 32'd0);
    check("rst_flags", {30'd0, bus.done_o, bus.err_o}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Good frame, back-to-back bytes, tx_ready low for 50 cycles.
    wr0 = n_wr; done0 = n_done; err0 = n_err;
    send_byte(8'hA5);
    check("a_hold_sync", {31'd0, bus.hold_o}, 32'd1);
    send_word(32'h0000_1000);
    send_byte(8'h02); send_byte(8'h00);
    send_word(32'h4433_2211);
    send_word(32'h8877_6655);
    send_byte(8'h9A);
    rx_off();
    check("a_txv",  {31'd0, bus.tx_valid_o}, 32'd1);
    check("a_txd",  {24'd0, bus.tx_data_o}, 32'h06);
    check("a_hold", {31'd0, bus.hold_o}, 32'd1);
    check("a_nwr",  n_wr - wr0, 32'd2);
    check("a_addr0", wr_addr[wr0],     32'h0000_1000);
    check("a_data0", wr_data[wr0],     32'h4433_2211);
    check("a_addr1", wr_addr[wr0 + 1], 32'h0000_1004);
    check("a_data1", wr_data[wr0 + 1], 32'h8877_6655);
    stable = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.tx_valid_o !== 1'b1 || bus.tx_data_o !== 8'h06 || bus.hold_o !== 1'b1) stable = 1'b0;
    end
    check("a_stable", {31'd0, stable}, 32'd1);
    do_handshake("a", 1'b1, 1'b0);
    check("a_ndone", n_done - done0, 32'd1);
    check("a_nerr",  n_err - err0, 32'd0);

    // Bad checksum: writes still happen, NAK.
    wr0 = n_wr; done0 = n_done; err0 = n_err;
    send_hdr(32'h0000_1000, 16'd2);
    send_word(32'h4433_2211);
    send_word(32'h8877_6655);
    send_byte(8'h9B);
    rx_off();
    check("b_txd", {24'd0, bus.tx_data_o}, 32'h15);
    check("b_nwr", n_wr - wr0, 32'd2);
    do_handshake("b", 1'b0, 1'b1);
    check("b_ndone", n_done - done0, 32'd0);
    check("b_nerr",  n_err - err0, 32'd1);

    // COUNT 0: immediate NAK, no writes.
    wr0 = n_wr;
    send_hdr(32'h0000_2000, 16'd0);
    rx_off();
    check("z_txv", {31'd0, bus.tx_valid_o}, 32'd1);
    check("z_txd", {24'd0, bus.tx_data_o}, 32'h15);
    do_handshake("z", 1'b0, 1'b1);
    check("z_nwr", n_wr - wr0, 32'd0);

    // Junk before SYNC, then wrapping frame at 0xFFFFFFFC.
    send_byte(8'h00); send_byte(8'hFF);
    rx_off();
    @(negedge clk);
    check("j_hold", {31'd0, bus.hold_o}, 32'd0);
    check("j_txv",  {31'd0, bus.tx_valid_o}, 32'd0);
    wr0 = n_wr;
    send_hdr(32'hFFFF_FFFC, 16'd2);
    send_word(32'h0403_0201);
    send_word(32'h0807_0605);
    send_byte(8'h09);
    rx_off();
    check("w_txd", {24'd0, bus.tx_data_o}, 32'h06);
    check("w_nwr", n_wr - wr0, 32'd2);
    check("w_addr0", wr_addr[wr0],     32'hFFFF_FFFC);
    check("w_data0", wr_data[wr0],     32'h0403_0201);
    check("w_addr1", wr_addr[wr0 + 1], 32'h0000_0000);
    check("w_data1", wr_data[wr0 + 1], 32'h0807_0605);
    do_handshake("w", 1'b1, 1'b0);

    // Timeout after three ADDR bytes.
    err0 = n_err;
    send_byte(8'hA5);
    send_byte(8'h00); send_byte(8'h10); send_byte(8'h00);
    rx_off();
    repeat (38) @(negedge clk);
    check("t_err_early", {31'd0, bus.err_o}, 32'd0);
    check("t_hold_early", {31'd0, bus.hold_o}, 32'd1);
    @(negedge clk);
    check("t_err_fire", {31'd0, bus.err_o}, 32'd1);
    @(negedge clk);
    check("t_err_after", {31'd0, bus.err_o}, 32'd0);
    check("t_hold_after", {31'd0, bus.hold_o}, 32'd0);
    check("t_txv", {31'd0, bus.tx_valid_o}, 32'd0);
    check("t_nerr", n_err - err0, 32'd1);
    wr0 = n_wr;
    send_hdr(32'h0000_1000, 16'd2);
    send_word(32'h4433_2211);
    send_word(32'h8877_6655);
    send_byte(8'h9A);
    rx_off();
    check("t2_txd", {24'd0, bus.tx_data_o}, 32'h06);
    check("t2_addr1", wr_addr[wr0 + 1], 32'h0000_1004);
    do_handshake("t2", 1'b1, 1'b0);

    // en_i dropped mid-DATA.
    wr0 = n_wr;
    send_hdr(32'h0000_3000, 16'd2);
    send_word(32'h4433_2211);
    send_byte(8'h55); send_byte(8'h66);
    rx_off();
    bus.en_i = 1'b0;
    #1;
    check("e_hold_now", {31'd0, bus.hold_o}, 32'd0);
    repeat (3) @(negedge clk);
    bus.en_i = 1'b1;
    send_byte(8'h77); send_byte(8'h88); send_byte(8'h9A);
    rx_off();
    repeat (2) @(negedge clk);
    check("e_nwr", n_wr - wr0, 32'd1);
    check("e_addr0", wr_addr[wr0], 32'h0000_3000);
    check("e_hold", {31'd0, bus.hold_o}, 32'd0);
    check("e_txv",  {31'd0, bus.tx_valid_o}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_loader.md
# uart_loader

Boot/debug loader that consumes the received-byte stream of the UART peripheral and writes program images into instruction/data memory over a simple write port. It sits directly downstream of the UART receiver and upstream of the memory write arbiter. While a frame is in progress it holds the CPU. It returns a one-byte ACK/NAK to the UART transmit path.

## Interface
- SYNC_BYTE, 8'hA5: frame start marker.
- ACK_BYTE, 8'h06: response for a good checksum.
- NAK_BYTE, 8'h15: response for a bad checksum or zero count.
- TIMEOUT, 32'd5_000_000: inter-byte timeout in clk cycles (100 ms at 50 MHz).

- clk  in  1  system clock (50 MHz)
- rst_n  in  1  reset, synchronous, active-low
- en_i  in  1  loader enable; 0 forces IDLE and drops all outputs
- rx_valid_i  in  1  one-cycle pulse, received byte available
- rx_data_i  in  8  received byte, valid with rx_valid_i
- tx_ready_i  in  1  UART transmitter can accept a byte
- tx_valid_o  out  1  response byte pending
- tx_data_o  out  8  response byte
- mem_we_o  out  1  one-cycle memory write strobe
- mem_addr_o  out  32  byte address of the word written, word-aligned
- mem_wdata_o  out  32  word written
- hold_o  out  1  CPU hold/stall request
- done_o  out  1  one-cycle pulse: frame accepted (ACK sent)
- err_o  out  1  one-cycle pulse: NAK issued or timeout abort

## Operation
- Frame format, all multi-byte fields little-endian: SYNC, ADDR[4], COUNT[2] (word count), DATA[4*COUNT], CHK[1].
- CHK = XOR of every byte after SYNC up to and including the last DATA byte.
- States:
  - IDLE: non-SYNC bytes are ignored. SYNC moves to ADDR, clears byte index, word index and checksum.
  - ADDR: after 4 bytes, moves to CNT.
  - CNT: after 2 bytes, moves to DATA; if COUNT==0, moves to RESP with NAK.
  - DATA: after 4*COUNT bytes, moves to CHK.
  - CHK: if the byte equals the running XOR, moves to RESP with ACK; otherwise moves to RESP with NAK.
  - RESP: holds tx_valid_o until tx_ready_i is sampled high, then returns to IDLE.
- Word assembly: byte k of a word lands in bits [8k+7:8k].
- Word address: mem_addr_o = {ADDR[31:2],2'b00} + 4*word_index. ADDR[1:0] is ignored. Arithmetic is 32-bit and wraps modulo 2^32.
- Writes are issued as each word completes. A NAK does not roll back words already written.
- hold_o is 1 from the cycle after SYNC is accepted until the cycle after the RESP handshake completes, or until a timeout/en_i abort.
- Timeout:
  - In ADDR/CNT/DATA/CHK, a cycle counter resets on every rx_valid_i.
  - Reaching TIMEOUT returns to IDLE, pulses err_o, sends no response and drops hold_o.
- Bytes arriving during RESP are dropped. A SYNC arriving mid-frame is treated as ordinary data.
- en_i=0, or reset mid-frame: return to IDLE immediately. Any pending response is discarded.

## Timing
- Reset values: tx_valid_o=0, tx_data_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, hold_o=0, done_o=0, err_o=0. State is IDLE; all counters are 0.
- Each rx_valid_i pulse is consumed in the cycle it is sampled. Back-to-back pulses on consecutive cycles must be accepted.
- mem_we_o, mem_addr_o and mem_wdata_o are registered. They are valid one cycle after the 4th byte of a word is sampled, and mem_we_o is high for exactly 1 cycle.
- tx_valid_o and tx_data_o go high one cycle after the CHK byte (or the final COUNT byte, for COUNT==0). tx_data_o is stable while tx_valid_o is high.
- done_o (ACK) or err_o (NAK) pulses in the same cycle the tx handshake completes.
- A timeout fires on the cycle the counter equals TIMEOUT-1. err_o pulses that cycle and hold_o falls the next cycle.
- COUNT max is 65535 words. The byte counter is at least 18 bits.

## Test plan
- Frame A5, 00 10 00 00, 02 00, 11 22 33 44, 55 66 77 88, CHK = correct XOR (ACK):
  - mem writes 0x1000←0x44332211 and 0x1004←0x88776655;
  - tx 0x06 after tx_ready_i; done_o pulses; hold_o is high for the whole frame.
- Same frame with CHK xor 0x01:
  - both writes still occur;
  - tx 0x15; err_o pulses; done_o stays 0.
- Frame with COUNT 00 00: no writes, immediate NAK 0x15.
- Junk bytes 0x00/0xFF before SYNC: ignored and hold_o stays 0. The subsequent valid frame is accepted normally.
- Stall after 3 ADDR bytes for TIMEOUT cycles: err_o pulses, hold_o drops, no tx. The next frame loads correctly.
- Timing and abort checks:
  - Back-to-back rx_valid_i every cycle, with tx_ready_i held low for 50 cycles: tx_valid_o and tx_data_o remain stable.
  - en_i deasserted mid-DATA forces IDLE with no further writes.
  - ADDR=0xFFFFFFFC with COUNT 2 writes 0xFFFFFFFC then 0x00000000.
